// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin sharing of one Integer_divider between two requesters.
// Define DIV_WATCHDOG_EN to add a WAIT-state watchdog that aborts a hung divider.
module div_share_arbiter #(
   parameter int W       = 4,
   parameter int TIMEOUT = 64
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         req0,
   input  logic [W-1:0] dvd0,
   input  logic [W-1:0] dvs0,
   input  logic         req1,
   input  logic [W-1:0] dvd1,
   input  logic [W-1:0] dvs1,
   output logic         ack0,
   output logic         ack1,
   output logic [W-1:0] q_out,
   output logic [W-1:0] r_out,
   output logic         err_out,
   output logic         busy,
   output logic         div_go,
   output logic [W-1:0] div_dividend,
   output logic [W-1:0] div_divisor,
   input  logic         div_done,
   input  logic         div_err,
   input  logic [W-1:0] div_q,
   input  logic [W-1:0] div_r,
   output logic         div_abort
);
   localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, RESP = 2'd3;
   logic [1:0] state;
   logic       gnt, last, sel, done, tmo;
   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("div_share_arbiter: TIMEOUT must be within 2..255");
   end
   // on a tie the port that was not served last wins
   assign sel  = req1 && (!req0 || !last);
   assign done = div_done || div_err;
`ifdef DIV_WATCHDOG_EN
   logic [7:0] cnt;
   assign tmo = state == WAIT && !done && cnt == 8'(TIMEOUT - 1);
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         cnt <= '0;
      else if (state == LAUNCH)
         cnt <= '0;
      else if (state == WAIT)
         cnt <= cnt + 8'd1;
   end
`else
   assign tmo = 1'b0;
`endif
   assign div_abort = tmo;
   assign busy      = state != IDLE;
   assign div_go    = state == LAUNCH;
   assign ack0      = state == RESP && !gnt;
   assign ack1      = state == RESP && gnt;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         gnt          <= 1'b0;
         last         <= 1'b1;
         q_out        <= '0;
         r_out        <= '0;
         err_out      <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
      end else begin
         case (state)
            IDLE: if (req0 || req1) begin
               gnt          <= sel;
               div_dividend <= sel ? dvd1 : dvd0;
               div_divisor  <= sel ? dvs1 : dvs0;
               state        <= LAUNCH;
            end
            LAUNCH: state <= WAIT;
            // a timeout leaves done low, which reports as an error with zeroed results
            WAIT: if (done || tmo) begin
               q_out   <= done && !div_err ? div_q : '0;
               r_out   <= done && !div_err ? div_r : '0;
               err_out <= div_err || !done;
               state   <= RESP;
            end
            default: begin
               last  <= gnt;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: scoreboard bench with a behavioural divider and round-robin reference model.
module tb_div_share_arbiter;
   localparam int W   = 4;
   localparam int TMO = 8;
   logic         CLK = 1'b0, RST = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0] dvd0 = '0, dvs0 = '0, dvd1 = '0, dvs1 = '0;
   logic         ack0, ack1, err_out, busy, div_go, div_abort;
   logic [W-1:0] q_out, r_out, div_dividend, div_divisor;
   logic         div_done = 1'b0, div_err = 1'b0;
   logic [W-1:0] div_q = '0, div_r = '0;
   int vectors = 0, miscompares = 0;
   typedef struct {int dvd; int dvs; int q; int r; int err;} exp_t;
   exp_t expq0[$], expq1[$];
   bit   hang = 1'b0;
   int   lat_fixed = -1;
   int   cyc = 0, go_cyc = 0, gos = 0, aborts = 0, acks0 = 0, acks1 = 0;

   div_share_arbiter #(.W(W), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .req0(req0), .dvd0(dvd0), .dvs0(dvs0),
      .req1(req1), .dvd1(dvd1), .dvs1(dvs1),
      .ack0(ack0), .ack1(ack1), .q_out(q_out), .r_out(r_out), .err_out(err_out),
      .busy(busy), .div_go(div_go), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_done(div_done), .div_err(div_err), .div_q(div_q), .div_r(div_r),
      .div_abort(div_abort)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, want finish");
      $fatal(1);
   end

   task automatic chk(string name, int act, int want);
      vectors++;
      if (act != want) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   function automatic exp_t model(int a, int b);
      exp_t e;
      e.dvd = a;
      e.dvs = b;
      if (hang || b == 0) begin
         e.q = 0; e.r = 0; e.err = 1;
      end else begin
         e.q = a / b; e.r = a % b; e.err = 0;
      end
      return e;
   endfunction

   // behavioural divider: Go clears Done, result appears after a random or fixed latency
   initial begin
      int dcnt = -1;
      int a = 0, b = 0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            div_done = 1'b0; div_err = 1'b0; dcnt = -1;
         end else if (div_go) begin
            div_done = 1'b0; div_err = 1'b0;
            a = int'(div_dividend); b = int'(div_divisor);
            dcnt = lat_fixed >= 0 ? lat_fixed : int'($urandom_range(0, 4));
         end
         if (!RST && dcnt == 0 && !hang) begin
            if (b == 0) begin
               div_err = 1'b1; div_q = W'($urandom); div_r = W'($urandom);
            end else begin
               div_done = 1'b1; div_q = W'(a / b); div_r = W'(a % b);
            end
         end
         if (dcnt >= 0) dcnt--;
      end
   end

   // monitor: predicts each grant from sampled requests and checks every ack against the scoreboard
   initial begin
      bit   last = 1'b1, gnt_exp = 1'b0, idle_p = 1'b0, r0p = 1'b0, r1p = 1'b0, p;
      exp_t e;
      forever begin
         @(negedge CLK);
         cyc++;
         if (RST) last = 1'b1;
         else begin
            if (div_go) begin
               gos++;
               go_cyc = cyc;
               gnt_exp = (r0p && r1p) ? !last : r1p;
               chk("go_after_idle_request", int'(idle_p && (r0p || r1p)), 1);
               if (gnt_exp ? expq1.size() == 0 : expq0.size() == 0)
                  chk("grant_has_pending", 0, 1);
               else begin
                  e = gnt_exp ? expq1[0] : expq0[0];
                  chk("div_dividend", int'(div_dividend), e.dvd);
                  chk("div_divisor", int'(div_divisor), e.dvs);
               end
            end
            if (div_abort) begin
               aborts++;
               chk("abort_cycle", cyc - go_cyc, TMO);
            end
            if (ack0 || ack1) begin
               chk("ack_onehot", int'(ack0 && ack1), 0);
               p = ack1;
               chk("ack_port", int'(p), int'(gnt_exp));
               if (p) acks1++; else acks0++;
               if (p ? expq1.size() == 0 : expq0.size() == 0)
                  chk("ack_expected", 0, 1);
               else begin
                  if (p) e = expq1.pop_front(); else e = expq0.pop_front();
                  chk("q_out", int'(q_out), e.q);
                  chk("r_out", int'(r_out), e.r);
                  chk("err_out", int'(err_out), e.err);
               end
               last = p;
            end
         end
         idle_p = !busy;
         r0p = req0;
         r1p = req1;
      end
   end

   task automatic raise(bit p, int a, int b);
      if (p) begin req1 = 1'b1; dvd1 = W'(a); dvs1 = W'(b); expq1.push_back(model(a, b)); end
      else   begin req0 = 1'b1; dvd0 = W'(a); dvs0 = W'(b); expq0.push_back(model(a, b)); end
   endtask

   task automatic wait_ack(bit p);
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!(p ? ack1 : ack0) && n < 300);
      if (!(p ? ack1 : ack0)) chk(p ? "ack1_timeout" : "ack0_timeout", 0, 1);
   endtask

   task automatic drop(bit p);
      @(posedge CLK);
      #1;
      if (p) req1 = 1'b0; else req0 = 1'b0;
   endtask

   task automatic op(bit p, int a, int b);
      @(posedge CLK);
      #1;
      raise(p, a, b);
      wait_ack(p);
      drop(p);
   endtask

   task automatic held(bit p, int a, int b, int n);
      @(posedge CLK);
      #1;
      raise(p, a, b);
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            if (p) expq1.push_back(model(a, b)); else expq0.push_back(model(a, b));
         end
         wait_ack(p);
      end
      drop(p);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #2;
      RST = 1'b1;
      expq0.delete();
      expq1.delete();
      repeat (2) @(negedge CLK);
      #2;
      RST = 1'b0;
   endtask

   task automatic rand_port(bit p, int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge CLK);
         op(p, int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15)));
      end
   endtask

   initial begin
      int g0, a1, ab0, k0;
      repeat (3) @(negedge CLK);
      chk("rst_busy", int'(busy), 0);
      chk("rst_acks", int'({ack0, ack1}), 0);
      chk("rst_go_abort", int'({div_go, div_abort}), 0);
      chk("rst_results", int'({q_out, r_out, err_out}), 0);
      chk("rst_operands", int'({div_dividend, div_divisor}), 0);
      #2;
      RST = 1'b0;

      g0 = gos; a1 = acks1;
      op(0, 13, 4);
      chk("single_go_count", gos - g0, 1);
      chk("single_no_ack1", acks1 - a1, 0);

      do_reset();
      fork
         op(0, 9, 2);
         op(1, 15, 5);
      join
      @(negedge CLK);
      chk("tie_busy_after", int'(busy), 0);

      k0 = acks0; a1 = acks1;
      fork
         held(0, 7, 7, 2);
         held(1, 8, 3, 2);
      join
      chk("held_acks0", acks0 - k0, 2);
      chk("held_acks1", acks1 - a1, 2);

      op(1, 5, 0);
      op(1, 5, 1);

      lat_fixed = 20;
      @(posedge CLK);
      #1;
      raise(0, 11, 2);
      g0 = 0;
      while (!div_go && g0 < 50) begin @(negedge CLK); g0++; end
      chk("rst_test_go_seen", int'(div_go), 1);
      repeat (3) @(negedge CLK);
      #2;
      RST = 1'b1;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_acks", int'({ack0, ack1}), 0);
      chk("async_rst_results", int'({q_out, r_out, err_out}), 0);
      chk("async_rst_operands", int'({div_dividend, div_divisor, div_go, div_abort}), 0);
      expq0.delete();
      expq1.delete();
      lat_fixed = -1;
      raise(0, 6, 3);
      repeat (2) @(negedge CLK);
      #2;
      RST = 1'b0;
      wait_ack(0);
      drop(0);

      hang = 1'b1;
      ab0 = aborts; k0 = acks0;
      @(posedge CLK);
      #1;
      raise(0, 9, 3);
`ifdef DIV_WATCHDOG_EN
      wait_ack(0);
      drop(0);
      chk("watchdog_abort_pulses", aborts - ab0, 1);
      hang = 1'b0;
`else
      repeat (100) @(negedge CLK);
      chk("hang_busy", int'(busy), 1);
      chk("hang_no_ack", acks0 - k0, 0);
      chk("hang_no_abort", aborts - ab0, 0);
      req0 = 1'b0;
      hang = 1'b0;
      do_reset();
`endif

      fork
         rand_port(0, 25);
         rand_port(1, 25);
      join
      repeat (5) @(negedge CLK);
      chk("final_busy", int'(busy), 0);
      chk("final_pending", expq0.size() + expq1.size(), 0);
`ifdef DIV_WATCHDOG_EN
      chk("total_aborts", aborts, 1);
`else
      chk("total_aborts", aborts, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one 4-bit Integer_divider instance between two requesters, e.g. the calculator key-entry path (port 0) and the expression/replay sequencer (port 1).
- Arbitrates round-robin, latches the granted operands, pulses the divider's Go, and waits for Done/Err.
- Returns Quotient/Remainder/Err to the granted port with a one-cycle ack.
- Sits between the requesters and the divider's Go/Dividend/Divisor/Done/Err/Quotient/Remainder pins.

Parameters:
- W, 4, operand/result width; must match the divider width.
- TIMEOUT, 64, watchdog cycle limit; used only when DIV_WATCHDOG_EN is defined; range 2..255.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous active-high reset
- req0  input  1  port 0 request level; held until ack0
- dvd0  input  W  port 0 dividend; stable while req0 high
- dvs0  input  W  port 0 divisor; stable while req0 high
- req1  input  1  port 1 request level
- dvd1  input  W  port 1 dividend
- dvs1  input  W  port 1 divisor
- ack0  output  1  one-cycle completion pulse, port 0
- ack1  output  1  one-cycle completion pulse, port 1
- q_out  output  W  registered quotient of the last completed op
- r_out  output  W  registered remainder of the last completed op
- err_out  output  1  registered error of the last completed op (div-by-zero or timeout)
- busy  output  1  high in any state other than IDLE
- div_go  output  1  Go pulse to the divider
- div_dividend  output  W  latched dividend to the divider
- div_divisor  output  W  latched divisor to the divider
- div_done  input  1  divider Done
- div_err  input  1  divider Err
- div_q  input  W  divider Quotient
- div_r  input  W  divider Remainder
- div_abort  output  1  one-cycle pulse on watchdog expiry; the integrator ORs it into the divider RST. Tied 0 without the macro.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, last-served=1, so port 0 wins the first tie.
  - All outputs 0: ack0/1, q_out, r_out, err_out, busy, div_go, div_dividend, div_divisor, div_abort.
  - Reset mid-operation abandons the op with no ack. The divider is reset by the same RST.
- FSM states: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req is high, grant per the round-robin rule.
  - Latch the granted dvd/dvs into div_dividend/div_divisor and record the grant index.
  - Go to LAUNCH.
- Round-robin rule:
  - Single request: that port wins.
  - Both requests high: the port not served last wins.
- LAUNCH: div_go=1 for exactly this one cycle; next state is WAIT.
- WAIT:
  - Completion is div_done=1 or div_err=1, sampled at the clock edge. The divider clears Done on Go, so no stale Done is seen.
  - On completion, register q_out<=div_q, r_out<=div_r, err_out<=div_err, then go to RESP.
  - If div_err=1, q_out and r_out are forced to 0.
- RESP:
  - ack for the granted port = 1 for this single cycle.
  - last-served <= granted index; next state is IDLE.
- Result registers hold until the next completion.
- Minimum latency from req sampled in IDLE to ack is 3 cycles plus the divider's own latency.
- A requester must drop req in the cycle after its ack. If req is still high in IDLE, it is treated as a new request, subject to round-robin.
- Requests that arrive while busy are held pending. The latched operands are unaffected by input changes after grant.
- Divisor 0 is forwarded unchanged; the divider's Err propagates to err_out.

Optional Feature:
- Macro: DIV_WATCHDOG_EN.
- Defined:
  - An 8-bit counter clears on LAUNCH and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without completion, the next state is RESP with err_out=1, q_out=0, r_out=0, and div_abort=1 for one cycle (the WAIT->RESP transition edge).
  - The normal ack follows.
- Not defined:
  - WAIT has no limit.
  - div_abort is constant 0 and the counter is absent.

Test Plan:
- req0, 13/4 alone: div_go pulses once, div_dividend=13, div_divisor=4; one ack0 with q_out=3, r_out=1, err_out=0; ack1 never asserted.
- req0 (9/2) and req1 (15/5) raised in the same cycle after reset: port 0 served first (q=4, r=1), then port 1 (q=3, r=0); exactly one ack each; busy drops after the second RESP.
- Both requests held high continuously with 7/7 and 8/3: grants alternate 0,1,0,1 over four ops; results are correct per port.
- req1, 5/0: err_out=1, q_out=0, r_out=0, single ack1; a following req1 of 5/1 gives q=5, r=0, err=0.
- RST asserted during WAIT: all outputs 0 asynchronously with no ack; after release, a pending req0 of 6/3 completes with q=2.
- DIV_WATCHDOG_EN, TIMEOUT=8, div_done/div_err forced 0: div_abort pulses once and ack0 follows with err_out=1. Without the macro, busy stays 1 and no ack is issued.
